aac_row_sequencer: RTL and testbench
====================================

Name: aac_row_sequencer

Overview:
- Controller that sequences the 28-bit split-pipeline adder-accumulator for matrix-vector product rows.
- Accepts a stream of signed products and drives the accumulator's aac/A_i inputs: load on the first column, accumulate on the rest, zero-add bubbles on input stalls.
- Captures each row sum from the accumulator output and presents it on a valid/ready result port.
- Sits between the MV multiplier array and the output buffer.

Parameters:
- COLS, 128, maximum columns per row.
- CNT_W, 8, width of column length/counter; must hold COLS.
- ROW_W, 8, width of row count/counter.
- DATA_W, 28, product/accumulator width; fixed to 28 to match the accumulator.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; launches a job using len_i/rows_i.
- len_i  in  CNT_W  columns per row, valid 1..COLS.
- rows_i  in  ROW_W  rows in the job, valid >=1.
- prod_valid_i  in  1  product beat valid.
- prod_data_i  in  DATA_W  signed product.
- prod_ready_o  out  1  product beat accepted when valid&ready.
- aac_o  out  1  to accumulator aac: 0 = load, 1 = accumulate.
- a_o  out  DATA_W  to accumulator A_i.
- acc_i  in  DATA_W  accumulator out.
- res_valid_o  out  1  row result valid.
- res_data_o  out  DATA_W  row sum.
- res_ready_i  in  1  result consumer ready.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse when the last row's result is accepted.
- stall_cnt_o  out  16  bubble counter (optional feature).

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE.
  - prod_ready_o=0, aac_o=0, a_o=0.
  - res_valid_o=0, res_data_o=0, busy_o=0, done_o=0, stall_cnt_o=0.
  - col/row counters 0.
- Accumulator timing contract:
  - Inputs presented in cycle t are reflected in acc_i in cycle t+1.
  - a_o=0 with aac_o=1 holds the accumulated value.
- States: IDLE, ACCUM, FLUSH, OUT.
- IDLE:
  - prod_ready_o=0, a_o=0, aac_o=0.
  - start_i with len_i in 1..COLS and rows_i>=0x01: latch len/rows, col=0, row=0, go to ACCUM.
  - start_i with len_i=0, len_i>COLS or rows_i=0: ignored, stays IDLE, no done.
- ACCUM:
  - prod_ready_o=1.
  - On beat (valid&ready): a_o=prod_data_i; aac_o=0 if col==0, else 1; col++.
  - No beat: a_o=0, aac_o=1 (bubble). The bubble's aac_o=1 is harmless on col==0 because the first real beat reloads.
  - On the beat where col==len-1: prod_ready_o deasserts next cycle, go to FLUSH.
- FLUSH (1 cycle):
  - a_o=0, aac_o=1, prod_ready_o=0.
  - Register res_data_o<=acc_i; res_valid_o<=1; go to OUT.
- OUT:
  - res_valid_o held, res_data_o stable until res_valid_o&res_ready_i.
  - a_o=0, aac_o=1.
  - On handshake: res_valid_o<=0; row++.
  - If row==rows-1: done_o pulses next cycle, go to IDLE.
  - Else: col=0, go to ACCUM.
- Latency: last product beat at cycle t -> res_valid_o at t+2. Minimum row period is len+2 cycles.
- Arithmetic: no widening, wraps mod 2^28 as the accumulator does. The controller performs no saturation.
- start_i while busy_o=1: ignored.
- Reset mid-operation: immediate return to IDLE, pending result discarded, no done_o. The next job's first beat uses aac_o=0, so stale accumulator state is irrelevant.
- len=1: one beat with aac_o=0, then FLUSH.
- Simultaneous res_ready_i and new prod_valid_i in OUT: product is not accepted until the ACCUM state is entered.

Optional Feature:
- Macro AAC_SEQ_STALL_CNT_EN.
- Defined:
  - stall_cnt_o counts cycles in ACCUM with no beat, plus cycles in OUT with res_ready_i=0.
  - Saturates at 0xFFFF; cleared on reset and on accepted start_i.
- Undefined: counter logic absent; stall_cnt_o tied to 0.

Test Plan:
- len=3, rows=1, products 5,7,-2 back-to-back, res_ready_i=1 -> aac_o sequence 0,1,1; res_data_o=10 two cycles after last beat; done_o pulse one cycle after handshake.
- len=2, products 0x0003FFF, 0x0000001 -> res_data_o=0x0004000 (carry across 14-bit split).
- len=2, products -1,-1 -> res_data_o=0xFFFFFFE; len=1, product 0x8000000 -> 0x8000000.
- len=4, products 1,2,3,4, prod_valid_i low 3 cycles between beats 2 and 3 -> bubbles drive a_o=0/aac_o=1; result 10; with macro, stall_cnt_o=3.
- rows=2, len=2, res_ready_i held low 5 cycles on row 0 -> res_data_o stable, prod_ready_o=0 throughout; row 1 starts with aac_o=0 and yields an independent sum.
- reset asserted mid-row (col=2 of 4) -> next-cycle IDLE, all outputs 0, no done_o; new job len=1, product 9 -> result 9.

Source files
------------

// File: rtl/aac_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aac_row_sequencer
// Description : Drives the 28-bit split-pipeline adder-accumulator for
//               matrix-vector rows and returns each row sum on a valid/ready
//               port. Optional macro: AAC_SEQ_STALL_CNT_EN (bubble counter).
// Revision    : 1.0 - initial release
// ============================================================================
module aac_row_sequencer #(
    parameter int COLS   = 128,
    parameter int CNT_W  = 8,
    parameter int ROW_W  = 8,
    parameter int DATA_W = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [ROW_W-1:0]  rows_i,
    input  logic              prod_valid_i,
    input  logic [DATA_W-1:0] prod_data_i,
    output logic              prod_ready_o,
    output logic              aac_o,
    output logic [DATA_W-1:0] a_o,
    input  logic [DATA_W-1:0] acc_i,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] res_data_o,
    input  logic              res_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       stall_cnt_o
);

    localparam logic [CNT_W:0] c_cols_max = (CNT_W+1)'(COLS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   rows_q, rows_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic               done_q, done_d;

    logic               w_start_ok;

    assign w_start_ok = start_i && (len_i != '0) && ({1'b0, len_i} <= c_cols_max)
                        && (rows_i != '0);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        col_d        = col_q;
        rows_d       = rows_q;
        row_d        = row_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        done_d       = 1'b0;
        prod_ready_o = 1'b0;
        aac_o        = 1'b0;
        a_o          = '0;

        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    len_d   = len_i;
                    rows_d  = rows_i;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                prod_ready_o = 1'b1;
                if (prod_valid_i) begin
                    a_o   = prod_data_i;
                    aac_o = (col_q != '0);
                    col_d = col_q + CNT_W'(1);
                    if (col_q == len_q - CNT_W'(1)) begin
                        state_d = S_FLUSH;
                    end
                end else begin
                    // Zero-add bubble keeps the running sum intact.
                    aac_o = 1'b1;
                end
            end
            S_FLUSH: begin
                // acc_i now reflects the last beat presented one cycle ago.
                aac_o       = 1'b1;
                res_data_d  = acc_i;
                res_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                aac_o = 1'b1;
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    row_d       = row_q + ROW_W'(1);
                    if (row_q == rows_q - ROW_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        col_d   = '0;
                        state_d = S_ACCUM;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            col_q       <= '0;
            rows_q      <= '0;
            row_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            col_q       <= col_d;
            rows_q      <= rows_d;
            row_q       <= row_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != S_IDLE);

`ifdef AAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && w_start_ok) begin
            stall_cnt_d = '0;
        end else if (((state_q == S_ACCUM) && !prod_valid_i) ||
                     ((state_q == S_OUT) && !res_ready_i)) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aac_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aac_row_sequencer
// Description : Directed bench for aac_row_sequencer with an accumulator model
//               and a result scoreboard. Honours AAC_SEQ_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aac_row_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [7:0]  len_i;
    logic [7:0]  rows_i;
    logic        prod_valid_i;
    logic [27:0] prod_data_i;
    logic        prod_ready_o;
    logic        aac_o;
    logic [27:0] a_o;
    logic [27:0] acc_i;
    logic        res_valid_o;
    logic [27:0] res_data_o;
    logic        res_ready_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] stall_cnt_o;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [27:0] exp_q[$];
    logic [27:0] mon_exp;
    logic [27:0] acc_q = '0;

    aac_row_sequencer #(
        .COLS   (128),
        .CNT_W  (8),
        .ROW_W  (8),
        .DATA_W (28)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .len_i        (len_i),
        .rows_i       (rows_i),
        .prod_valid_i (prod_valid_i),
        .prod_data_i  (prod_data_i),
        .prod_ready_o (prod_ready_o),
        .aac_o        (aac_o),
        .a_o          (a_o),
        .acc_i        (acc_i),
        .res_valid_o  (res_valid_o),
        .res_data_o   (res_data_o),
        .res_ready_i  (res_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural accumulator: one-cycle latency, wraps mod 2^28.
    always @(posedge clk) acc_q <= aac_o ? (acc_q + a_o) : a_o;
    assign acc_i = acc_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every accepted result pops one expected row sum.
    always @(negedge clk) begin
        if (!reset && res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got %0h expected none at %0t", res_data_o, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("row_sum", {4'h0, res_data_o}, {4'h0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] l, input logic [7:0] r);
        start_i = 1'b1;
        len_i   = l;
        rows_i  = r;
        tick();
        start_i = 1'b0;
        check("busy_after_start", {31'd0, busy_o}, 32'd1);
    endtask

    task automatic beat(input logic [27:0] d, input logic exp_aac);
        prod_valid_i = 1'b1;
        prod_data_i  = d;
        #1;
        check("beat_aac", {31'd0, aac_o}, {31'd0, exp_aac});
        check("beat_a", {4'h0, a_o}, {4'h0, d});
        check("beat_ready", {31'd0, prod_ready_o}, 32'd1);
        tick();
        prod_valid_i = 1'b0;
    endtask

    task automatic bubble(input int n);
        prod_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("bubble_a", {4'h0, a_o}, 32'd0);
            check("bubble_aac", {31'd0, aac_o}, 32'd1);
            check("bubble_ready", {31'd0, prod_ready_o}, 32'd1);
            tick();
        end
    endtask

    // Called in the cycle right after the last beat (FLUSH).
    task automatic finish_row(input logic [27:0] exp, input logic last);
        exp_q.push_back(exp);
        #1;
        check("flush_valid", {31'd0, res_valid_o}, 32'd0);
        check("flush_ready", {31'd0, prod_ready_o}, 32'd0);
        check("flush_aac", {31'd0, aac_o}, 32'd1);
        tick();
        check("latency_valid", {31'd0, res_valid_o}, 32'd1);
        tick();
        if (last) begin
            check("done_pulse", {31'd0, done_o}, 32'd1);
            check("idle_busy", {31'd0, busy_o}, 32'd0);
            tick();
            check("done_low", {31'd0, done_o}, 32'd0);
        end else begin
            check("no_done_mid", {31'd0, done_o}, 32'd0);
            check("busy_mid", {31'd0, busy_o}, 32'd1);
        end
    endtask

    task automatic bad_start(input logic [7:0] l, input logic [7:0] r);
        start_i = 1'b1;
        len_i   = l;
        rows_i  = r;
        tick();
        start_i = 1'b0;
        check("bad_start_busy", {31'd0, busy_o}, 32'd0);
        tick();
        check("bad_start_done", {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        start_i      = 1'b0;
        len_i        = '0;
        rows_i       = '0;
        prod_valid_i = 1'b0;
        prod_data_i  = '0;
        res_ready_i  = 1'b1;
        repeat (3) tick();

        check("rst_flags", {27'd0, busy_o, prod_ready_o, aac_o, res_valid_o, done_o}, 32'd0);
        check("rst_a", {4'h0, a_o}, 32'd0);
        check("rst_res_data", {4'h0, res_data_o}, 32'd0);
        check("rst_stall", {16'd0, stall_cnt_o}, 32'd0);
        reset = 1'b0;
        tick();

        // 5 + 7 - 2; a start during the job must be ignored
        start_job(8'd3, 8'd1);
        beat(28'd5, 1'b0);
        start_i = 1'b1;
        len_i   = 8'd1;
        beat(28'd7, 1'b1);
        start_i = 1'b0;
        beat(28'hFFFFFFE, 1'b1);
        finish_row(28'd10, 1'b1);

        // carry across the 14-bit split
        start_job(8'd2, 8'd1);
        beat(28'h0003FFF, 1'b0);
        beat(28'h0000001, 1'b1);
        finish_row(28'h0004000, 1'b1);

        start_job(8'd2, 8'd1);
        beat(28'hFFFFFFF, 1'b0);
        beat(28'hFFFFFFF, 1'b1);
        finish_row(28'hFFFFFFE, 1'b1);

        start_job(8'd1, 8'd1);
        beat(28'h8000000, 1'b0);
        finish_row(28'h8000000, 1'b1);

        bad_start(8'd0, 8'd1);
        bad_start(8'd129, 8'd1);
        bad_start(8'd4, 8'd0);

        // three bubbles between beats 2 and 3
        start_job(8'd4, 8'd1);
        beat(28'd1, 1'b0);
        beat(28'd2, 1'b1);
        bubble(3);
        beat(28'd3, 1'b1);
        beat(28'd4, 1'b1);
        finish_row(28'd10, 1'b1);
`ifdef AAC_SEQ_STALL_CNT_EN
        check("stall_cnt", {16'd0, stall_cnt_o}, 32'd3);
`else
        check("stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
`endif

        // two rows, consumer back-pressure on row 0 with a product waiting
        start_job(8'd2, 8'd2);
        beat(28'd4, 1'b0);
        beat(28'd5, 1'b1);
        exp_q.push_back(28'd9);
        res_ready_i  = 1'b0;
        prod_valid_i = 1'b1;
        prod_data_i  = 28'd100;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_valid", {31'd0, res_valid_o}, 32'd1);
            check("hold_data", {4'h0, res_data_o}, 32'd9);
            check("hold_ready", {31'd0, prod_ready_o}, 32'd0);
            check("hold_aac", {31'd0, aac_o}, 32'd1);
            check("hold_a", {4'h0, a_o}, 32'd0);
            tick();
        end
        res_ready_i = 1'b1;
        #1;
        check("hs_no_accept", {31'd0, prod_ready_o}, 32'd0);
        tick();
        check("row0_no_done", {31'd0, done_o}, 32'd0);
        beat(28'd100, 1'b0);
        beat(28'hFFFFFFD, 1'b1);
        finish_row(28'd97, 1'b1);

        // reset at col=2 of 4; pending row discarded
        start_job(8'd4, 8'd1);
        beat(28'd1, 1'b0);
        beat(28'd2, 1'b1);
        reset        = 1'b1;
        prod_valid_i = 1'b1;
        prod_data_i  = 28'd3;
        tick();
        reset        = 1'b0;
        prod_valid_i = 1'b0;
        #1;
        check("midrst_flags", {27'd0, busy_o, prod_ready_o, aac_o, res_valid_o, done_o}, 32'd0);
        check("midrst_a", {4'h0, a_o}, 32'd0);
        check("midrst_res_data", {4'h0, res_data_o}, 32'd0);
        check("midrst_stall", {16'd0, stall_cnt_o}, 32'd0);
        tick();
        check("midrst_no_done", {31'd0, done_o}, 32'd0);
        start_job(8'd1, 8'd1);
        beat(28'd9, 1'b0);
        finish_row(28'd9, 1'b1);

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
